// File: rtl/floating_divide.sv
// Iterative IEEE-754 single-precision divider (out = a / b), restoring division, one quotient bit per clock.
// Define FLOATING_DIVIDE_DEBUG_EN to expose the unclamped result exponent on an extra debug port.
module floating_divide #(
  parameter int unsigned QBITS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
`ifdef FLOATING_DIVIDE_DEBUG_EN
  , output logic [31:0] debug
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t             state, next_state;
  logic [QBITS-1:0]   q;
  logic [25:0]        rem;
  logic [23:0]        dvs;
  logic [4:0]         count;
  logic [7:0]         aexp, bexp;
  logic               sign, sp_inf, sp_zero;

  logic               a_zero, b_zero, ge;
  logic [25:0]        rem_sel;
  logic signed [9:0]  e;
  logic [22:0]        frac;
  logic [31:0]        result;

  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);

  // Restoring step: subtract only when the partial remainder covers the divisor.
  assign ge      = (rem >= {2'b00, dvs});
  assign rem_sel = ge ? (rem - {2'b00, dvs}) : rem;

  assign e = $signed({2'b00, aexp}) - $signed({2'b00, bexp}) + 10'sd126
           + $signed({9'b0, q[QBITS-1]});
  assign frac = q[QBITS-1] ? q[23:1] : q[22:0];

  always_comb begin
    if (sp_inf)
      result = {sign, 8'hFF, 23'h0};
    else if (sp_zero)
      result = {sign, 31'h0};
    else if (e >= 10'sd255)
      result = {sign, 8'hFF, 23'h0};
    else if (e <= 10'sd0)
      result = {sign, 31'h0};
    else
      result = {sign, e[7:0], frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (a_zero || b_zero) ? NORM : CALC;
      CALC: if (count == 5'(QBITS - 1)) next_state = NORM;
      NORM: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == NORM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      q           <= '0;
      rem         <= '0;
      dvs         <= '0;
      count       <= '0;
      aexp        <= '0;
      bexp        <= '0;
      sign        <= 1'b0;
      sp_inf      <= 1'b0;
      sp_zero     <= 1'b0;
`ifdef FLOATING_DIVIDE_DEBUG_EN
      debug       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign    <= a[31] ^ b[31];
          aexp    <= a[30:23];
          bexp    <= b[30:23];
          sp_inf  <= b_zero;
          sp_zero <= a_zero & ~b_zero;
          rem     <= {3'b001, a[22:0]};
          dvs     <= {1'b1, b[22:0]};
          count   <= '0;
          q       <= '0;
        end
        CALC: begin
          q     <= {q[QBITS-2:0], ge};
          rem   <= rem_sel << 1;
          count <= count + 5'd1;
        end
        NORM: begin
          done        <= 1'b1;
          div_by_zero <= sp_inf;
          out         <= result;
`ifdef FLOATING_DIVIDE_DEBUG_EN
          debug       <= {{22{e[9]}}, e};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
